// File: rtl/adder_stream_pkg.sv
// Shared types and helpers for the adder stream controller.
// Contents:
//   WIDTH       default operand width
//   state_t     controller FSM states
//   res_entry_t default-width result FIFO entry layout
//   signed_ovf  two's-complement overflow from the operand/result sign bits
package adder_stream_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic           ovf;
  } res_entry_t;

  // Overflow occurs when both operands share a sign and the result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic f_msb);
    return (a_msb == b_msb) && (f_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_result_fifo.sv
// Synchronous first-word-fall-through result FIFO.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (clears pointers, count and storage)
//   push_i        write push_data_i at the tail
//   push_data_i   entry to store
//   pop_i         consume the head (ignored while empty)
//   head_o        current head entry, zero while empty
//   valid_o       FIFO holds at least one entry
//   count_o       number of entries held
module adder_result_fifo #(
  parameter int DW    = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH < 2) || ((1 << PW) != DEPTH)) begin : g_bad_depth
    $error("adder_result_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok_s;

  assign pop_ok_s = pop_i && (count_q != {CW{1'b0}});
  assign valid_o  = (count_q != {CW{1'b0}});
  assign head_o   = valid_o ? mem_q[rd_ptr_q] : {DW{1'b0}};
  assign count_o  = count_q;

  // Next pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_ok_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/adder_stream_ctrl.sv
// Sequential wrapper for an external combinational adder treated as a multi-cycle path.
// Operands are accepted over in_valid/in_ready, held on add_a/add_b for SETTLE_CYCLES
// cycles, then add_f is captured into a result FIFO drained over out_valid/out_ready.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake, in_a/in_b operands
//   add_a/add_b/add_f      connection to the external adder
//   out_valid/out_ready    result handshake, out_sum FIFO head (WIDTH+1 bits)
//   fifo_count             entries held, busy = waiting for the adder to settle
//   out_ovf                signed overflow of the head entry (only with SIGNED_OVF_EN)
// Build option: define SIGNED_OVF_EN to store and expose the signed overflow flag.
module adder_stream_ctrl
  import adder_stream_pkg::*;
#(
  parameter int WIDTH         = adder_stream_pkg::WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  output logic [WIDTH-1:0]              add_a,
  output logic [WIDTH-1:0]              add_b,
  input  logic [WIDTH:0]                add_f,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH:0]                out_sum,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
`ifdef SIGNED_OVF_EN
  ,
  output logic                          out_ovf
`endif
);

  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
`ifdef SIGNED_OVF_EN
  localparam int DW  = WIDTH + 2;
`else
  localparam int DW  = WIDTH + 1;
`endif

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("adder_stream_ctrl: SETTLE_CYCLES must be >= 1");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             accept_s;
  logic             capture_s;
  logic [DW-1:0]    wr_data_s;
  logic [DW-1:0]    head_s;

  // The free-slot check at accept time guarantees room at capture: only pops can happen meanwhile.
  assign in_ready = (state_q == IDLE) && (fifo_count < FCW'(FIFO_DEPTH));
  assign accept_s = in_valid && in_ready;
  assign busy     = (state_q == SETTLE);
  assign add_a    = a_q;
  assign add_b    = b_q;

  // FSM next state, settle countdown and operand load.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == {CW{1'b0}}) begin
          capture_s = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // FSM, counter and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

`ifdef SIGNED_OVF_EN
  assign wr_data_s = {add_f, signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], add_f[WIDTH-1])};
  assign out_sum   = head_s[DW-1:1];
  assign out_ovf   = head_s[0];
`else
  assign wr_data_s = add_f;
  assign out_sum   = head_s;
`endif

  adder_result_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (capture_s),
    .push_data_i (wr_data_s),
    .pop_i       (out_ready),
    .head_o      (head_s),
    .valid_o     (out_valid),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Self-checking bench for adder_stream_ctrl; add_f comes from a behavioural 32-bit adder.
module tb_adder_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [32:0] add_f;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [32:0] out_sum;
  logic [2:0]  fifo_count;
  logic        busy;
`ifdef SIGNED_OVF_EN
  logic        out_ovf;
`endif

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  // Stand-in for bit32adder.
  assign add_f = {1'b0, add_a} + {1'b0, add_b};

  adder_stream_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_f      (add_f),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .fifo_count (fifo_count),
    .busy       (busy)
`ifdef SIGNED_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  // Expected entry {ovf, sum} straight from the arithmetic definition.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic        o;
    s = {1'b0, a} + {1'b0, b};
    o = (a[31] == b[31]) && (s[31] != a[31]);
    return {o, s};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present the pair for exactly the accept edge.
  task automatic op_accept(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", 64'(n < 50), 64'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int offered;
    int accepted;
    bit acc_pending;
    logic [33:0] e;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: 100 + 200, result visible two edges after accept
    op_accept(32'd100, 32'd200);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd0);
    chk("t1_add_a", 64'(add_a), 64'd100);
    tick();
    chk("t1_valid_early", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_sum", 64'(out_sum), 64'h0_0000_012C);
    chk("t1_busy_done", 64'(busy), 64'd0);
    pop_one();
    chk("t1_drained", 64'(fifo_count), 64'd0);

    // 2: carry into bit 32
    op_accept(32'hFFFF_FFFF, 32'd1);
    tick();
    tick();
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_sum", 64'(out_sum), 64'h1_0000_0000);
    pop_one();

    // 3: fill the FIFO with out_ready low, fifth pair must be held off
    for (int i = 1; i <= 4; i++) begin
      op_accept(32'(i), 32'(i));
      exp_q.push_back(model(32'(i), 32'(i)));
    end
    tick();
    tick();
    chk("t3_full_count", 64'(fifo_count), 64'd4);
    chk("t3_full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_a = 32'd5;
    in_b = 32'd5;
    exp_q.push_back(model(32'd5, 32'd5));
    repeat (5) tick();
    chk("t3_held_ready", 64'(in_ready), 64'd0);
    chk("t3_held_count", 64'(fifo_count), 64'd4);
    chk("t3_held_busy", 64'(busy), 64'd0);
    chk("t3_held_add_a", 64'(add_a), 64'd4);
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() > 0 || in_valid) && n < 100) begin
      if (in_valid && busy) in_valid = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("t3_extra", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("t3_order", 64'(out_sum), 64'(e[32:0]));
        end
      end
      tick();
      n++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("t3_drain_done", 64'(n < 100), 64'd1);
    chk("t3_empty", 64'(fifo_count), 64'd0);

    // 4: asynchronous reset mid-SETTLE with two entries queued
    op_accept(32'd1, 32'd2);
    op_accept(32'd3, 32'd4);
    tick();
    tick();
    chk("t4_queued", 64'(fifo_count), 64'd2);
    op_accept(32'd5, 32'd6);
    chk("t4_busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_add_a", 64'(add_a), 64'd0);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_fifo_count", 64'(fifo_count), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_still_empty", 64'(out_valid), 64'd0);

    // 5: pop and capture on the same edge
    op_accept(32'd10, 32'd20);
    tick();
    tick();
    chk("t5_one", 64'(fifo_count), 64'd1);
    op_accept(32'd7, 32'd8);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_count", 64'(fifo_count), 64'd1);
    chk("t5_head", 64'(out_sum), 64'd15);
    pop_one();
    chk("t5_empty", 64'(fifo_count), 64'd0);

`ifdef SIGNED_OVF_EN
    // 6: signed overflow flag
    chk("t6_ovf_empty", 64'(out_ovf), 64'd0);
    op_accept(32'h7FFF_FFFF, 32'd1);
    tick();
    tick();
    chk("t6a_ovf", 64'(out_ovf), 64'd1);
    chk("t6a_sum", 64'(out_sum), 64'h0_8000_0000);
    pop_one();
    op_accept(32'hFFFF_FFFF, 32'd1);
    tick();
    tick();
    chk("t6b_ovf", 64'(out_ovf), 64'd0);
    pop_one();
    op_accept(32'h8000_0000, 32'h8000_0000);
    tick();
    tick();
    chk("t6c_ovf", 64'(out_ovf), 64'd1);
    chk("t6c_sum", 64'(out_sum), 64'h1_0000_0000);
    pop_one();
`endif

    // Randomized traffic with random back-pressure against the queue model
    offered = 0;
    accepted = 0;
    acc_pending = 1'b0;
    n = 0;
    while ((accepted < 40 || exp_q.size() > 0 || in_valid) && n < 3000) begin
      if (acc_pending) begin
        in_valid = 1'b0;
        acc_pending = 1'b0;
      end
      if (!in_valid && offered < 40 && $urandom_range(0, 1) == 1) begin
        in_a = $urandom;
        in_b = $urandom;
        in_valid = 1'b1;
        offered++;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      chk("rnd_valid_vs_count", 64'(out_valid), 64'(fifo_count != 3'd0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_sum", 64'(out_sum), 64'(e[32:0]));
`ifdef SIGNED_OVF_EN
          chk("rnd_ovf", 64'(out_ovf), 64'(e[33]));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b));
        acc_pending = 1'b1;
        accepted++;
      end
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("rnd_complete", 64'(n < 3000), 64'd1);
    chk("rnd_final_empty", 64'(fifo_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
